// File: rtl/buf_id_pkg.sv
// Shared types and defaults for the buffer ID scheduler.
// Holds the FSM state encoding, pool geometry defaults and the ID-to-address helper.
package buf_id_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_ID_W      = 4;
    localparam int DEF_ID_NUM    = 16;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_BLK_SHIFT = 7;

    // Cache base address of a buffer block: the ID followed by BLK_SHIFT zeros.
    function automatic logic [DEF_ADDR_W-1:0] id_base_addr(
        input logic [DEF_ID_W-1:0] id
    );
        return DEF_ADDR_W'({id, {DEF_BLK_SHIFT{1'b0}}});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// Ports: req_i request vector, ptr_i search start; gnt_o one-hot, sel_o index, valid_o any.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   sel_o,
    output logic               valid_o
);

    always_comb begin
        gnt_o   = '0;
        sel_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                valid_o = 1'b1;
                gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
                sel_o = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/buf_id_sched.sv
// Buffer ID pool scheduler: owns the free-ID list, grants IDs round-robin, recycles releases.
// Ports: req_valid in / grant, grant_id, grant_waddr out; rel_wr, rel_id in / rel_ready out;
// free_count, init_done, err_ovf status out. Synchronous active-high rst.
module buf_id_sched
    import buf_id_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = DEF_ID_W,
    parameter int ID_NUM    = DEF_ID_NUM,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BLK_SHIFT = DEF_BLK_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic [ADDR_W-1:0]  grant_waddr,
    input  logic               rel_wr,
    input  logic [ID_W-1:0]    rel_id,
    output logic               rel_ready,
    output logic [ID_W:0]      free_count,
    output logic               init_done,
    output logic               err_ovf
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0]   FULL = (ID_W+1)'(ID_NUM);
    localparam logic [ID_W-1:0] LAST = ID_W'(ID_NUM - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ID_W:0]        count_q, count_d;
    logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 init_done_q, init_done_d;
    logic                 rel_ready_q, rel_ready_d;
    logic                 err_ovf_q, err_ovf_d;
    logic [ID_W-1:0]      fifo_q [ID_NUM];
    logic [ID_W-1:0]      fifo_d [ID_NUM];

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [RR_W-1:0]      arb_sel;
    logic                 arb_valid;
    logic                 pop, push;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (RR_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .sel_o   (arb_sel),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        grant_id_d  = grant_id_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        init_done_d = init_done_q;
        rel_ready_d = rel_ready_q;
        err_ovf_d   = err_ovf_q;
        fifo_d      = fifo_q;
        pop         = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            INIT: begin
                // Identity fill: location k holds ID k.
                fifo_d[wr_ptr_q] = wr_ptr_q;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + 1'b1;
                if (wr_ptr_q == LAST) begin
                    init_done_d = 1'b1;
                    rel_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (count_q != '0 && arb_valid) begin
                    pop        = 1'b1;
                    grant_d    = arb_gnt;
                    grant_id_d = fifo_q[rd_ptr_q];
                    rr_ptr_d   = (arb_sel == RR_W'(NUM_REQ - 1)) ?
                                 '0 : arb_sel + 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: state_d = IDLE;
            default: state_d = INIT;
        endcase

        // Releases are judged against the registered count, so a full
        // list rejects a release even if a pop happens this cycle.
        if (state_q != INIT && rel_wr) begin
            if (count_q == FULL) begin
                err_ovf_d = 1'b1;
            end else begin
                fifo_d[wr_ptr_q] = rel_id;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                push     = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            init_done_q <= 1'b0;
            rel_ready_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            init_done_q <= init_done_d;
            rel_ready_q <= rel_ready_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    // Storage only; contents are rebuilt by INIT after every reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_waddr = ADDR_W'(id_base_addr(grant_id_q));
    assign free_count  = count_q;
    assign init_done   = init_done_q;
    assign rel_ready   = rel_ready_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_buf_id_sched.sv
// Scoreboard bench for buf_id_sched against a queue-based pool model.
// Stimulus drives at negedge+1; a monitor pops expected grants at each negedge.
module tb_buf_id_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  grant;
    logic [3:0]  grant_id;
    logic [10:0] grant_waddr;
    logic        rel_wr;
    logic [3:0]  rel_id;
    logic        rel_ready;
    logic [4:0]  free_count;
    logic        init_done;
    logic        err_ovf;

    always #5 clk = ~clk;

    buf_id_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_waddr (grant_waddr),
        .rel_wr      (rel_wr),
        .rel_id      (rel_id),
        .rel_ready   (rel_ready),
        .free_count  (free_count),
        .init_done   (init_done),
        .err_ovf     (err_ovf)
    );

    typedef struct {
        logic [3:0]  g;
        logic [3:0]  id;
        logic [10:0] wa;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] free_m[$];
    int         rr_m;
    bit         hold_m;
    bit         err_m;
    int         last_sel;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Pool model: a grant may follow a grant only after one idle cycle;
    // fullness for releases is judged before this cycle's pop.
    task automatic model(input logic [3:0] req, input bit rw,
                         input logic [3:0] rid);
        int   sz0;
        int   sel;
        exp_t e;
        sz0      = free_m.size();
        sel      = -1;
        last_sel = -1;
        if (!hold_m && sz0 > 0 && req != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (sel < 0 && req[(rr_m + i) % 4]) sel = (rr_m + i) % 4;
            end
            e.g  = 4'(1 << sel);
            e.id = free_m.pop_front();
            e.wa = 11'(int'(e.id) * 128);
            exp_q.push_back(e);
            rr_m     = (sel + 1) % 4;
            hold_m   = 1'b1;
            last_sel = sel;
        end else begin
            hold_m = 1'b0;
        end
        if (rw) begin
            if (sz0 == 16) err_m = 1'b1;
            else free_m.push_back(rid);
        end
    endtask

    task automatic step(input logic [3:0] req, input bit rw,
                        input logic [3:0] rid);
        chk("missed_grant", exp_q.size(), 0);
        chk("free_count", free_count, free_m.size());
        chk("err_ovf", err_ovf, err_m);
        chk("rel_ready", rel_ready, 1);
        req_valid = req;
        rel_wr    = rw;
        rel_id    = rid;
        model(req, rw, rid);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rel_wr    = 1'b0;
        rel_id    = '0;
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_waddr", grant_waddr, 0);
        chk("rst_free_count", free_count, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rel_ready", rel_ready, 0);
        chk("rst_err_ovf", err_ovf, 0);
        exp_q.delete();
        free_m.delete();
        rr_m   = 0;
        hold_m = 1'b0;
        err_m  = 1'b0;
        rst    = 1'b0;
        // Releases during fill must be ignored.
        rel_wr = 1'b1;
        rel_id = 4'd7;
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) rel_wr = 1'b0;
            @(negedge clk);
            #1;
            chk("init_done_timing", init_done, (k == 16));
            chk("init_grant", grant, 0);
        end
        for (int q = 0; q < 16; q++) free_m.push_back(4'(q));
        chk("init_free_count", free_count, 16);
        chk("init_rel_ready", rel_ready, 1);
        chk("init_err_ovf", err_ovf, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && grant !== 4'd0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_grant: got %b expected none", grant);
            end else begin
                e = exp_q.pop_front();
                chk("grant", grant, e.g);
                chk("grant_id", grant_id, e.id);
                chk("grant_waddr", grant_waddr, e.wa);
            end
        end
    end

    initial begin
        logic [3:0] reqm;
        rst       = 1'b1;
        req_valid = '0;
        rel_wr    = 1'b0;
        rel_id    = '0;

        do_reset();

        // Single requester, two grants: IDs 0 then 1.
        step(4'b0001, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0001, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);

        // All four request; each drops after its grant.
        do_reset();
        reqm = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step(reqm, 1'b0, 4'd0);
            if (last_sel >= 0) reqm[last_sel] = 1'b0;
        end

        // Drain, starve, then one release feeds requester 2.
        for (int i = 0; i < 40 && free_m.size() > 0; i++)
            step(4'b0100, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 4'd0);
        step(4'b0100, 1'b1, 4'd5);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);

        // Refill to 8, then pop and push in the same cycle.
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 4'(i));
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0100, 1'b1, 4'd9);
        step(4'b0000, 1'b0, 4'd0);
        chk("count_after_push_pop", free_count, 8);
        for (int i = 0; i < 30 && free_m.size() > 0; i++)
            step(4'b0010, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)));
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);

        // Double free on a full list, then reset during a grant pulse.
        do_reset();
        step(4'b0000, 1'b1, 4'd3);
        step(4'b0000, 1'b0, 4'd0);
        chk("err_ovf_set", err_ovf, 1);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0001, 1'b0, 4'd0);
        chk("grant_before_reset", grant, 4'b0001);
        do_reset();
        step(4'b0010, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        chk("leftover_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
